// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: output-stationary multiply-accumulate processing element.
// Activations pass left->right, weights top->bottom, and results leave
// through a top->bottom drain shift chain. The accumulator is configurable
// for signed or unsigned operation, saturating or wrapping.
//
// Valid semantics: act_valid_in / wt_valid_in qualify the operands on the
// current edge. A pair is consumed (the MAC fires) only when both are high
// and en=1. There is no ready/backpressure. The only flow control is the
// global stall en, which freezes every register in the array at once.
// Operand data and valid bits are forwarded one cycle later regardless of
// whether the pair fired. drain_valid_* marks a meaningful result word in
// the drain chain.
module systolic_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SAT    = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              signed_mode,
  input  logic              clear,
  input  logic              capture,
  input  logic [DATA_W-1:0] act_in,
  input  logic              act_valid_in,
  input  logic [DATA_W-1:0] wt_in,
  input  logic              wt_valid_in,
  output logic [DATA_W-1:0] act_out,
  output logic              act_valid_out,
  output logic [DATA_W-1:0] wt_out,
  output logic              wt_valid_out,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_valid_in,
  input  logic              drain_ovf_in,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_valid_out,
  output logic              drain_ovf_out,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf,
  output logic [CNT_W-1:0]  mac_cnt
);

  // Arithmetic is carried out one bit wider than the accumulator so the
  // carry / sign-overflow of the sum is visible.
  localparam int XW = ACC_W + 1;

  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

  logic             fire;
  logic             a_sign;
  logic             w_sign;
  logic [XW-1:0]    a_ext;
  logic [XW-1:0]    w_ext;
  logic [XW-1:0]    prod;
  logic [XW-1:0]    acc_ext;
  logic [XW-1:0]    sum;
  logic             ovf_now;
  logic [ACC_W-1:0] sum_res;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  // Datapath: extend operands, multiply, add, detect overflow, clamp or wrap.
  always_comb begin
    fire    = act_valid_in & wt_valid_in;
    a_sign  = signed_mode & act_in[DATA_W-1];
    w_sign  = signed_mode & wt_in[DATA_W-1];
    // Operands are extended to the full XW width. The low XW bits of the
    // product of two extended values equal the exact product, which always
    // fits because ACC_W >= 2*DATA_W+1.
    a_ext   = {{(XW-DATA_W){a_sign}}, act_in};
    w_ext   = {{(XW-DATA_W){w_sign}}, wt_in};
    prod    = a_ext * w_ext;
    acc_ext = {signed_mode & acc[ACC_W-1], acc};
    sum     = acc_ext + prod;
    // Both addends fit in ACC_W signed bits, so a signed overflow shows up
    // as the top two bits of the XW-bit sum disagreeing.
    ovf_now = signed_mode ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    sum_res = sum[ACC_W-1:0];
    if (ovf_now && (SAT != 0)) begin
      if (signed_mode) sum_res = sum[ACC_W] ? SMIN : SMAX;
      else             sum_res = UMAX;
    end
    acc_next = fire ? sum_res : acc;
    ovf_next = ovf | (fire & ovf_now);
  end

  // State update: stall holds all; capture beats clear beats accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_out         <= '0;
      act_valid_out   <= 1'b0;
      wt_out          <= '0;
      wt_valid_out    <= 1'b0;
      drain_out       <= '0;
      drain_valid_out <= 1'b0;
      drain_ovf_out   <= 1'b0;
      acc             <= '0;
      ovf             <= 1'b0;
      mac_cnt         <= '0;
    end else if (en) begin
      act_out       <= act_in;
      act_valid_out <= act_valid_in;
      wt_out        <= wt_in;
      wt_valid_out  <= wt_valid_in;
      if (capture) begin
        // The pair on this edge is folded into the captured result.
        drain_out       <= acc_next;
        drain_valid_out <= 1'b1;
        drain_ovf_out   <= ovf_next;
        acc             <= '0;
        ovf             <= 1'b0;
        mac_cnt         <= '0;
      end else begin
        drain_out       <= drain_in;
        drain_valid_out <= drain_valid_in;
        drain_ovf_out   <= drain_ovf_in;
        if (clear) begin
          acc     <= '0;
          ovf     <= 1'b0;
          mac_cnt <= '0;
        end else begin
          acc <= acc_next;
          ovf <= ovf_next;
          if (fire && (mac_cnt != {CNT_W{1'b1}})) mac_cnt <= mac_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed testbench for systolic_mac_pe: a vector table on a default PE,
// 17-bit accumulator PEs for saturate/wrap, a 3-PE drain column, count
// saturation and asynchronous reset.
module tb_systolic_mac_pe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- main PE (defaults) ----------------
  logic        en, sm, clr, cap, av, wv, dv_in, dovf_in;
  logic [7:0]  act, wt;
  logic [23:0] din;
  logic [7:0]  act_o, wt_o;
  logic        av_o, wv_o, dv_o, dovf_o, ovf;
  logic [23:0] dout, acc;
  logic [7:0]  cnt;

  systolic_mac_pe dut (
    .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(sm), .clear(clr), .capture(cap),
    .act_in(act), .act_valid_in(av), .wt_in(wt), .wt_valid_in(wv),
    .act_out(act_o), .act_valid_out(av_o), .wt_out(wt_o), .wt_valid_out(wv_o),
    .drain_in(din), .drain_valid_in(dv_in), .drain_ovf_in(dovf_in),
    .drain_out(dout), .drain_valid_out(dv_o), .drain_ovf_out(dovf_o),
    .acc(acc), .ovf(ovf), .mac_cnt(cnt)
  );

  // ---------------- 17-bit PEs, saturating and wrapping ----------------
  logic        s_sm, s_clr, s_cap, s_v;
  logic [7:0]  s_act, s_wt;
  logic [16:0] s_din;
  logic [7:0]  sa_ao, sa_wo, wr_ao, wr_wo;
  logic        sa_avo, sa_wvo, wr_avo, wr_wvo;
  logic [16:0] sa_dout, sa_acc, wr_dout, wr_acc;
  logic        sa_dv, sa_dovf, sa_ovf, wr_dv, wr_dovf, wr_ovf;
  logic [7:0]  sa_cnt, wr_cnt;

  systolic_mac_pe #(.DATA_W(8), .ACC_W(17), .SAT(1), .CNT_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(s_sm), .clear(s_clr), .capture(s_cap),
    .act_in(s_act), .act_valid_in(s_v), .wt_in(s_wt), .wt_valid_in(s_v),
    .act_out(sa_ao), .act_valid_out(sa_avo), .wt_out(sa_wo), .wt_valid_out(sa_wvo),
    .drain_in(s_din), .drain_valid_in(1'b0), .drain_ovf_in(1'b0),
    .drain_out(sa_dout), .drain_valid_out(sa_dv), .drain_ovf_out(sa_dovf),
    .acc(sa_acc), .ovf(sa_ovf), .mac_cnt(sa_cnt)
  );

  systolic_mac_pe #(.DATA_W(8), .ACC_W(17), .SAT(0), .CNT_W(8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .signed_mode(s_sm), .clear(s_clr), .capture(s_cap),
    .act_in(s_act), .act_valid_in(s_v), .wt_in(s_wt), .wt_valid_in(s_v),
    .act_out(wr_ao), .act_valid_out(wr_avo), .wt_out(wr_wo), .wt_valid_out(wr_wvo),
    .drain_in(s_din), .drain_valid_in(1'b0), .drain_ovf_in(1'b0),
    .drain_out(wr_dout), .drain_valid_out(wr_dv), .drain_ovf_out(wr_dovf),
    .acc(wr_acc), .ovf(wr_ovf), .mac_cnt(wr_cnt)
  );

  // ---------------- 3-PE column (index 0 = top) ----------------
  logic        c_cap;
  logic [7:0]  c_act [3];
  logic [7:0]  c_wt  [3];
  logic        c_v   [3];
  logic [7:0]  c_ao  [3];
  logic [7:0]  c_wo  [3];
  logic        c_avo [3];
  logic        c_wvo [3];
  logic [23:0] c_dout[3];
  logic        c_dv  [3];
  logic        c_dovf[3];
  logic [23:0] c_acc [3];
  logic        c_ovf [3];
  logic [7:0]  c_cnt [3];
  logic [23:0] c_top_d;

  systolic_mac_pe u_col0 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .signed_mode(1'b0), .clear(1'b0), .capture(c_cap),
    .act_in(c_act[0]), .act_valid_in(c_v[0]), .wt_in(c_wt[0]), .wt_valid_in(c_v[0]),
    .act_out(c_ao[0]), .act_valid_out(c_avo[0]), .wt_out(c_wo[0]), .wt_valid_out(c_wvo[0]),
    .drain_in(c_top_d), .drain_valid_in(1'b0), .drain_ovf_in(1'b0),
    .drain_out(c_dout[0]), .drain_valid_out(c_dv[0]), .drain_ovf_out(c_dovf[0]),
    .acc(c_acc[0]), .ovf(c_ovf[0]), .mac_cnt(c_cnt[0])
  );
  systolic_mac_pe u_col1 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .signed_mode(1'b0), .clear(1'b0), .capture(c_cap),
    .act_in(c_act[1]), .act_valid_in(c_v[1]), .wt_in(c_wt[1]), .wt_valid_in(c_v[1]),
    .act_out(c_ao[1]), .act_valid_out(c_avo[1]), .wt_out(c_wo[1]), .wt_valid_out(c_wvo[1]),
    .drain_in(c_dout[0]), .drain_valid_in(c_dv[0]), .drain_ovf_in(c_dovf[0]),
    .drain_out(c_dout[1]), .drain_valid_out(c_dv[1]), .drain_ovf_out(c_dovf[1]),
    .acc(c_acc[1]), .ovf(c_ovf[1]), .mac_cnt(c_cnt[1])
  );
  systolic_mac_pe u_col2 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .signed_mode(1'b0), .clear(1'b0), .capture(c_cap),
    .act_in(c_act[2]), .act_valid_in(c_v[2]), .wt_in(c_wt[2]), .wt_valid_in(c_v[2]),
    .act_out(c_ao[2]), .act_valid_out(c_avo[2]), .wt_out(c_wo[2]), .wt_valid_out(c_wvo[2]),
    .drain_in(c_dout[1]), .drain_valid_in(c_dv[1]), .drain_ovf_in(c_dovf[1]),
    .drain_out(c_dout[2]), .drain_valid_out(c_dv[2]), .drain_ovf_out(c_dovf[2]),
    .acc(c_acc[2]), .ovf(c_ovf[2]), .mac_cnt(c_cnt[2])
  );

  // ---------------- vector table type ----------------
  typedef struct {
    logic        en, sm, clr, cap;
    logic [7:0]  act; logic av;
    logic [7:0]  wt;  logic wv;
    logic [23:0] din; logic dv, dovf;
    logic [23:0] e_acc; logic e_ovf; logic [7:0] e_cnt;
    logic [7:0]  e_act, e_wt;
    logic [23:0] e_dout; logic e_dv, e_dovf;
  } vec_t;

  vec_t vecs[13];

  // ---------------- driver tasks / checker ----------------
  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic drive_main(input vec_t v);
    en = v.en; sm = v.sm; clr = v.clr; cap = v.cap;
    act = v.act; av = v.av; wt = v.wt; wv = v.wv;
    din = v.din; dv_in = v.dv; dovf_in = v.dovf;
  endtask

  task automatic main_pair(input logic c, input logic [7:0] a, input logic [7:0] w);
    en = 1'b1; clr = c; cap = 1'b0; act = a; wt = w; av = 1'b1; wv = 1'b1;
    din = '0; dv_in = 1'b0; dovf_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic s_pair(input logic m, input logic c, input logic k, input logic [7:0] a,
                        input logic [7:0] w, input logic v);
    s_sm = m; s_clr = c; s_cap = k; s_act = a; s_wt = w; s_v = v;
    @(posedge clk); #1;
  endtask

  task automatic s_chk(input string tag, input logic [16:0] e_sat, input logic [16:0] e_wrap,
                       input logic e_ovf);
    chk({tag, " sat acc"},  32'(sa_acc), 32'(e_sat));
    chk({tag, " wrap acc"}, 32'(wr_acc), 32'(e_wrap));
    chk({tag, " sat ovf"},  32'(sa_ovf), 32'(e_ovf));
    chk({tag, " wrap ovf"}, 32'(wr_ovf), 32'(e_ovf));
  endtask

  // ---------------- stimulus ----------------
  logic e_av, e_wv;

  initial begin
    //            en    sm    clr   cap   act     av    wt     wv    din          dv    dovf   e_acc         e_ovf e_cnt  e_act  e_wt   e_dout        e_dv  e_dovf
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 8'd2,  1'b1, 8'd3,  1'b1, 24'd0,       1'b0,1'b0, 24'd6,        1'b0, 8'd1, 8'd2,  8'd3,  24'd0,        1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 8'd4,  1'b1, 8'd5,  1'b1, 24'd0,       1'b0,1'b0, 24'd26,       1'b0, 8'd2, 8'd4,  8'd5,  24'd0,        1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 8'd255,1'b1, 8'd255,1'b1, 24'd0,       1'b0,1'b0, 24'd65051,    1'b0, 8'd3, 8'd255,8'd255,24'd0,        1'b0,1'b0};
    // weight invalid: no MAC, data still forwarded; drain shifts through
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 8'd7,  1'b1, 8'd9,  1'b0, 24'h123456,  1'b1,1'b1, 24'd65051,    1'b0, 8'd3, 8'd7,  8'd9,  24'h123456,   1'b1,1'b1};
    // stall with a valid pair, then stall with clear+capture: nothing moves
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0, 8'd1,  1'b1, 8'd1,  1'b1, 24'h0000AA,  1'b0,1'b0, 24'd65051,    1'b0, 8'd3, 8'd7,  8'd9,  24'h123456,   1'b1,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b1, 8'd50, 1'b1, 8'd50, 1'b1, 24'd0,       1'b0,1'b0, 24'd65051,    1'b0, 8'd3, 8'd7,  8'd9,  24'h123456,   1'b1,1'b1};
    // clear+capture: capture wins, capture-cycle pair (1*2) included
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b1, 8'd1,  1'b1, 8'd2,  1'b1, 24'h777777,  1'b1,1'b1, 24'd0,        1'b0, 8'd0, 8'd1,  8'd2,  24'd65053,    1'b1,1'b0};
    // clear alone discards the pair; drain shifts normally
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b0, 8'd5,  1'b1, 8'd5,  1'b1, 24'd0,       1'b0,1'b0, 24'd0,        1'b0, 8'd0, 8'd5,  8'd5,  24'd0,        1'b0,1'b0};
    // signed: (-3)*4 then (-128)*(-128)
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b0, 8'hFD, 1'b1, 8'd4,  1'b1, 24'd0,       1'b0,1'b0, 24'hFFFFF4,   1'b0, 8'd1, 8'hFD, 8'd4,  24'd0,        1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 24'd0,       1'b0,1'b0, 24'h003FF4,   1'b0, 8'd2, 8'h80, 8'h80, 24'd0,        1'b0,1'b0};
    // capture with no pair, then back-to-back capture with (-1)*(-1)
    vecs[10] = '{1'b1,1'b1,1'b0,1'b1, 8'd0,  1'b0, 8'd0,  1'b0, 24'd0,       1'b0,1'b0, 24'd0,        1'b0, 8'd0, 8'd0,  8'd0,  24'd16372,    1'b1,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 24'd0,       1'b0,1'b0, 24'd0,        1'b0, 8'd0, 8'hFF, 8'hFF, 24'd1,        1'b1,1'b0};
    // unsigned tile: 255*1
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0, 8'hFF, 1'b1, 8'd1,  1'b1, 24'd5,       1'b1,1'b0, 24'd255,      1'b0, 8'd1, 8'hFF, 8'd1,  24'd5,        1'b1,1'b0};

    // idle inputs
    en = 1'b1; sm = 1'b0; clr = 1'b0; cap = 1'b0; act = '0; wt = '0; av = 1'b0; wv = 1'b0;
    din = '0; dv_in = 1'b0; dovf_in = 1'b0;
    s_sm = 1'b0; s_clr = 1'b0; s_cap = 1'b0; s_act = '0; s_wt = '0; s_v = 1'b0; s_din = '0;
    c_cap = 1'b0; c_top_d = '0;
    for (int i = 0; i < 3; i++) begin c_act[i] = '0; c_wt[i] = '0; c_v[i] = 1'b0; end

    // ---- reset state ----
    rst_n = 1'b0;
    #3;
    chk("reset acc", 32'(acc), 32'd0);
    chk("reset mac_cnt", 32'(cnt), 32'd0);
    chk("reset drain_valid", 32'(dv_o), 32'd0);
    chk("reset act_out", 32'(act_o), 32'd0);
    #9 rst_n = 1'b1;

    // ---- table-driven vectors on the main PE ----
    e_av = 1'b0; e_wv = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive_main(vecs[i]);
      @(posedge clk); #1;
      if (vecs[i].en) begin e_av = vecs[i].av; e_wv = vecs[i].wv; end
      chk($sformatf("v%0d acc", i),         32'(acc),    32'(vecs[i].e_acc));
      chk($sformatf("v%0d ovf", i),         32'(ovf),    32'(vecs[i].e_ovf));
      chk($sformatf("v%0d mac_cnt", i),     32'(cnt),    32'(vecs[i].e_cnt));
      chk($sformatf("v%0d act_out", i),     32'(act_o),  32'(vecs[i].e_act));
      chk($sformatf("v%0d act_valid", i),   32'(av_o),   32'(e_av));
      chk($sformatf("v%0d wt_out", i),      32'(wt_o),   32'(vecs[i].e_wt));
      chk($sformatf("v%0d wt_valid", i),    32'(wv_o),   32'(e_wv));
      chk($sformatf("v%0d drain_out", i),   32'(dout),   32'(vecs[i].e_dout));
      chk($sformatf("v%0d drain_valid", i), 32'(dv_o),   32'(vecs[i].e_dv));
      chk($sformatf("v%0d drain_ovf", i),   32'(dovf_o), 32'(vecs[i].e_dovf));
    end

    // ---- mac_cnt saturates at all-ones (zero products keep acc at 0) ----
    sm = 1'b0;
    main_pair(1'b1, 8'd1, 8'd0);
    for (int i = 0; i < 260; i++) main_pair(1'b0, 8'd1, 8'd0);
    chk("cnt sat mac_cnt", 32'(cnt), 32'd255);
    chk("cnt sat acc", 32'(acc), 32'd0);

    // ---- 17-bit signed positive overflow: 127*127 = 16129 per pair ----
    s_pair(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) s_pair(1'b1, 1'b0, 1'b0, 8'd127, 8'd127, 1'b1);
    s_chk("s17 4x", 17'd64516, 17'd64516, 1'b0);
    s_pair(1'b1, 1'b0, 1'b0, 8'd127, 8'd127, 1'b1);
    s_chk("s17 5x", 17'd65535, 17'd80645, 1'b1);
    // (-1)*1 after overflow: ovf stays sticky
    s_pair(1'b1, 1'b0, 1'b0, 8'hFF, 8'd1, 1'b1);
    s_chk("s17 sticky", 17'd65534, 17'd80644, 1'b1);

    // ---- 17-bit signed negative overflow: -128*127 = -16256 per pair ----
    s_pair(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("s17 clear ovf", 32'(sa_ovf), 32'd0);
    for (int i = 0; i < 4; i++) s_pair(1'b1, 1'b0, 1'b0, 8'h80, 8'd127, 1'b1);
    s_chk("s17 neg 4x", 17'd66048, 17'd66048, 1'b0);
    s_pair(1'b1, 1'b0, 1'b0, 8'h80, 8'd127, 1'b1);
    s_chk("s17 neg 5x", 17'd65536, 17'd49792, 1'b1);

    // ---- 17-bit unsigned overflow: 255*255 = 65025 per pair ----
    s_pair(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 2; i++) s_pair(1'b0, 1'b0, 1'b0, 8'd255, 8'd255, 1'b1);
    s_chk("u17 2x", 17'd130050, 17'd130050, 1'b0);
    s_pair(1'b0, 1'b0, 1'b0, 8'd255, 8'd255, 1'b1);
    s_chk("u17 3x", 17'd131071, 17'd64003, 1'b1);
    // capture carries the sticky flag into the drain chain
    s_pair(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    chk("u17 cap drain", 32'(sa_dout), 32'd131071);
    chk("u17 cap drain_ovf", 32'(sa_dovf), 32'd1);
    chk("u17 cap drain_valid", 32'(sa_dv), 32'd1);
    chk("u17 cap acc", 32'(sa_acc), 32'd0);
    chk("u17 cap ovf", 32'(sa_ovf), 32'd0);
    s_pair(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

    // ---- 3-PE column drain: load 10/20/30, capture with (1,1) at bottom ----
    c_act[0] = 8'd10; c_act[1] = 8'd20; c_act[2] = 8'd30;
    for (int i = 0; i < 3; i++) begin c_wt[i] = 8'd1; c_v[i] = 1'b1; end
    @(posedge clk); #1;
    chk("col load top", 32'(c_acc[0]), 32'd10);
    chk("col load bottom", 32'(c_acc[2]), 32'd30);
    c_v[0] = 1'b0; c_v[1] = 1'b0; c_act[2] = 8'd1; c_cap = 1'b1;
    @(posedge clk); #1;
    c_v[2] = 1'b0; c_cap = 1'b0;
    chk("col drain0 data", 32'(c_dout[2]), 32'd31);
    chk("col drain0 valid", 32'(c_dv[2]), 32'd1);
    for (int i = 0; i < 3; i++) chk($sformatf("col acc%0d zero", i), 32'(c_acc[i]), 32'd0);
    @(posedge clk); #1;
    chk("col drain1 data", 32'(c_dout[2]), 32'd20);
    chk("col drain1 valid", 32'(c_dv[2]), 32'd1);
    @(posedge clk); #1;
    chk("col drain2 data", 32'(c_dout[2]), 32'd10);
    chk("col drain2 valid", 32'(c_dv[2]), 32'd1);
    @(posedge clk); #1;
    chk("col drain3 valid", 32'(c_dv[2]), 32'd0);

    // ---- asynchronous reset mid-accumulation ----
    sm = 1'b0;
    main_pair(1'b1, 8'd0, 8'd0);
    din = 24'd9; dv_in = 1'b1;
    main_pair(1'b0, 8'd20, 8'd25);
    chk("pre-reset acc", 32'(acc), 32'd500);
    av = 1'b0; wv = 1'b0; din = 24'd9; dv_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst acc", 32'(acc), 32'd0);
    chk("async rst mac_cnt", 32'(cnt), 32'd0);
    chk("async rst act_out", 32'(act_o), 32'd0);
    chk("async rst drain_valid", 32'(dv_o), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
